// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with a one-deep holding register in front of
// the shifter; frames are start, data LSB first, optional parity, stop.
module uart_tx #(
   parameter int         data_bits             = 8,
   parameter int         bit_cell_counter_bits = 4,
   parameter logic [2:0] br                    = 3'b000,
   parameter int         parity_en             = 0,
   parameter int         parity_odd            = 0,
   parameter int         stop_bits             = 1
) (
   input  logic                 sysclk,
   input  logic                 rst,
   input  logic [data_bits-1:0] TDR,
   input  logic                 tdr_loadH,
   output logic                 txd,
   output logic                 tdr_emptyH,
   output logic                 txd_busyH,
   output logic                 txd_doneH
);

   localparam int         bw       = $clog2(data_bits);
   localparam int         sw       = bit_cell_counter_bits;
   localparam logic [6:0] pre_max  = 7'((1 << br) - 1);
   localparam logic [bw-1:0] bit_max = bw'(data_bits - 1);
   localparam logic       stop_max = 1'(stop_bits - 1);
   localparam logic       odd      = 1'(parity_odd);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t               state;
   state_t               state_nxt;
   logic [data_bits-1:0] hold;
   logic [data_bits-1:0] shifter;
   logic                 full;
   logic                 par;
   logic [6:0]           pre;
   logic [sw-1:0]        sub;
   logic [bw-1:0]        bit_cnt;
   logic                 stop_cnt;
   logic                 tick;
   logic                 cell_end;
   logic                 last_stop;
   logic                 load;
   logic                 xfer;
   logic                 txd_nxt;

   assign tick      = (pre == pre_max);
   assign cell_end  = tick && (sub == '1);
   assign last_stop = (state == STOP) && cell_end && (stop_cnt == stop_max);
   assign load      = tdr_loadH && !full;
   assign xfer      = full && ((state == IDLE) || last_stop);

   always_ff @(posedge sysclk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (full) state_nxt = START;
         START:   if (cell_end) state_nxt = DATA;
         DATA: begin
            if (cell_end && (bit_cnt == bit_max))
               state_nxt = (parity_en != 0) ? PARITY : STOP;
         end
         PARITY:  if (cell_end) state_nxt = STOP;
         STOP:    if (last_stop) state_nxt = full ? START : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // txd changes only at a cell boundary or when a frame starts from idle
   always_comb begin
      txd_nxt    = txd;
      tdr_emptyH = !full;
      txd_busyH  = (state != IDLE);
      txd_doneH  = last_stop;
      if (xfer || cell_end) begin
         case (state_nxt)
            START:   txd_nxt = 1'b0;
            DATA:    txd_nxt = (state == DATA) ? shifter[1] : shifter[0];
            PARITY:  txd_nxt = par;
            default: txd_nxt = 1'b1;
         endcase
      end
   end

   always_ff @(posedge sysclk) begin
      if (rst) begin
         txd      <= 1'b1;
         full     <= 1'b0;
         hold     <= '0;
         shifter  <= '0;
         par      <= 1'b0;
         pre      <= '0;
         sub      <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
      end else begin
         txd <= txd_nxt;
         if (load) begin
            hold <= TDR;
            full <= 1'b1;
         end else if (xfer) begin
            full <= 1'b0;
         end
         if (xfer) begin
            shifter <= hold;
            par     <= (^hold) ^ odd;
         end else if ((state == DATA) && cell_end) begin
            shifter <= shifter >> 1;
         end
         if ((state == IDLE) || xfer) begin
            pre <= '0;
            sub <= '0;
         end else begin
            pre <= tick ? 7'd0 : pre + 7'd1;
            if (tick) sub <= sub + sw'(1);
         end
         if (state != DATA)  bit_cnt <= '0;
         else if (cell_end)  bit_cnt <= bit_cnt + bw'(1);
         if (state != STOP)  stop_cnt <= 1'b0;
         else if (cell_end)  stop_cnt <= ~stop_cnt;
      end
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter that serializes parallel data onto txd: one start bit, data_bits LSB first, optional parity, stop bit(s).
- Pairs with the team's UART receiver.
- Uses the same baud-select encoding and 16-sub-tick bit-cell scheme as the receiver, so both ends agree on frame timing.
- Provides a one-deep transmit holding register (TDR) in front of the shift register, so the next frame can be queued and sent back-to-back.

Parameters:
- data_bits, 8, number of data bits per frame (5..9).
- bit_cell_counter_bits, 4, width of the sub-tick counter; one bit cell = 2^bit_cell_counter_bits baud ticks.
- br, 3'b000, baud select; baud tick every 2^br sysclk cycles (divide 1..128).
- parity_en, 0, 1 = append parity bit after the data bits.
- parity_odd, 0, when parity_en=1: 0 = even parity, 1 = odd parity.
- stop_bits, 1, number of stop bit cells (1 or 2).

Ports:
- sysclk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- TDR  in  data_bits  data word to transmit.
- tdr_loadH  in  1  load strobe; TDR is captured when tdr_loadH=1 and tdr_emptyH=1.
- txd  out  1  serial output, idle high.
- tdr_emptyH  out  1  holding register empty; a load is accepted now.
- txd_busyH  out  1  frame in progress in the shift register.
- txd_doneH  out  1  one-cycle pulse during the last sysclk cycle of the final stop cell.

Behaviour:
- Reset (rst=1 at an edge):
  - txd=1, tdr_emptyH=1, txd_busyH=0, txd_doneH=0.
  - Prescaler, sub-tick and bit counters cleared; state IDLE.
- Reset mid-frame: frame abandoned; txd returns to 1 after that edge; a queued holding word is discarded.
- Cell timing:
  - Prescaler counts 0..2^br-1 and emits a baud tick at terminal count.
  - The sub-tick counter advances on each baud tick; a bit cell ends when it wraps.
  - One bit cell = 16*2^br sysclk cycles at the default bit_cell_counter_bits.
  - Prescaler and sub-tick counter are reset to 0 at frame start, so every cell is exactly full length.
- Load:
  - Load sampled at edge E0 while tdr_emptyH=1: the holding register captures TDR and tdr_emptyH=0 after E0.
  - Load while tdr_emptyH=0 is ignored; the holding contents are unchanged.
- State machine (IDLE, START, DATA, PARITY, STOP):
  - IDLE: txd=1, txd_busyH=0. If the holding register is full, transfer to the shifter at the next edge E1.
    - After E1: txd=0, state START, txd_busyH=1, tdr_emptyH=1. Start-to-first-txd-low latency from the load edge is 2 edges.
  - START: one cell at txd=0, then DATA.
  - DATA: data_bits cells, shifter LSB first, bit counter 0..data_bits-1. Then PARITY if parity_en, else STOP.
  - PARITY: one cell at txd = XOR of the data bits, inverted when parity_odd=1.
  - STOP: stop_bits cells at txd=1. txd_doneH=1 in the final sysclk cycle of the last stop cell.
  - At the end of STOP: if the holding register is full, go directly to START with no idle gap (txd 1->0 at that edge). Otherwise go to IDLE.
- Frame length: (1 + data_bits + parity_en + stop_bits) cells.
- Simultaneous transfer and load: a load on the edge where the shifter takes the holding word is ignored, because tdr_emptyH was 0 in that cycle. The next load is accepted one cycle later.
- TDR is only sampled on an accepted load; changes to TDR mid-frame have no effect.
- txd is registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. Reset, idle 50 cycles -> txd=1, tdr_emptyH=1, txd_busyH=0, txd_doneH=0 throughout.
2. br=0, 8N1, load 8'hA5 at E0 -> txd low from E1.
   - Cells (16 cycles each) read 0, 1,0,1,0,0,1,0,1, 1.
   - txd_doneH is a single pulse in the 160th cycle after E1.
   - txd_busyH drops the next cycle.
3. Back-to-back: load 8'h55, then load 8'h0F once tdr_emptyH returns to 1 -> second start bit begins on the edge ending the first stop cell. No idle cycles; two txd_doneH pulses 160 cycles apart.
4. Load while tdr_emptyH=0 (third word 8'hFF while a frame is active and one word is queued) -> ignored; only the first two words appear on txd.
5. br=3'b010, parity_en=1, parity_odd=0, stop_bits=2, data 8'h07:
   - Each cell lasts 64 cycles; parity cell = 1; two stop cells.
   - Total 12 cells = 768 cycles.
   - Repeat with parity_odd=1 -> parity cell = 0.
6. Assert rst in DATA cell 4 of 8'hA5 with a word queued -> txd=1 after that edge, tdr_emptyH=1, txd_busyH=0, no txd_doneH. A new load afterwards transmits a clean full frame.
